// File: rtl/net_tx_credit_arbiter.sv
// Link-credit TX arbiter: splits the user-layer stream into controller/user queues, sends whole
// packets with strict controller priority, one credit per word. NET_TX_ARB_STATS_EN adds stat counters.
module net_tx_credit_arbiter #(
    parameter int DATA_W       = 128,
    parameter int FIFO_DEPTH   = 16,
    parameter int INIT_CREDITS = 16,
    parameter int MAX_CREDITS  = 32,
    localparam int CREDIT_W    = $clog2(MAX_CREDITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic                in_ctrl,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic                out_ctrl,
    input  logic                out_ready,
    input  logic                credit_return,
    output logic [CREDIT_W-1:0] credits_avail,
    output logic                credit_ovf_err
`ifdef NET_TX_ARB_STATS_EN
    ,
    output logic [31:0]         stat_ctrl_pkts,
    output logic [31:0]         stat_user_pkts,
    output logic [31:0]         stat_credit_stall
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SEND_CTRL, SEND_USER} state_t;

    state_t               state_q, state_d;
    logic                 in_sof_q, in_sof_d;
    logic                 pkt_ctrl_q, pkt_ctrl_d;
    logic                 ready_en_q, ready_en_d;
    logic [CREDIT_W-1:0]  credits_q, credits_d;
    logic                 ovf_q, ovf_d;
    logic [PTR_W-1:0]     ctrl_wr_ptr_q, ctrl_wr_ptr_d, ctrl_rd_ptr_q, ctrl_rd_ptr_d;
    logic [PTR_W-1:0]     user_wr_ptr_q, user_wr_ptr_d, user_rd_ptr_q, user_rd_ptr_d;
    logic [CNT_W-1:0]     ctrl_cnt_q, ctrl_cnt_d, user_cnt_q, user_cnt_d;

    logic [DATA_W:0]      ctrl_mem [FIFO_DEPTH];
    logic [DATA_W:0]      user_mem [FIFO_DEPTH];
    logic [DATA_W:0]      head;

    logic ctrl_full, ctrl_empty, user_full, user_empty;
    logic target_ctrl, in_fire, ctrl_push, user_push;
    logic sel_ctrl, sel_user, head_avail, head_last, credit_ok;
    logic out_fire, ctrl_pop, user_pop;

`ifdef NET_TX_ARB_STATS_EN
    logic [31:0] stat_ctrl_q, stat_ctrl_d, stat_user_q, stat_user_d, stat_stall_q, stat_stall_d;
`endif

    assign ctrl_full   = (ctrl_cnt_q == CNT_W'(FIFO_DEPTH));
    assign user_full   = (user_cnt_q == CNT_W'(FIFO_DEPTH));
    assign ctrl_empty  = (ctrl_cnt_q == '0);
    assign user_empty  = (user_cnt_q == '0);

    // Queue choice follows the flag on the first word and sticks for the rest of the packet.
    assign target_ctrl = in_sof_q ? in_ctrl : pkt_ctrl_q;
    assign in_ready    = ready_en_q && (target_ctrl ? !ctrl_full : !user_full);
    assign in_fire     = in_valid && in_ready;
    assign ctrl_push   = in_fire && target_ctrl;
    assign user_push   = in_fire && !target_ctrl;

    assign sel_ctrl    = (state_q == SEND_CTRL);
    assign sel_user    = (state_q == SEND_USER);
    assign head        = sel_ctrl ? ctrl_mem[ctrl_rd_ptr_q] : user_mem[user_rd_ptr_q];
    assign head_last   = head[0];
    assign head_avail  = (sel_ctrl && !ctrl_empty) || (sel_user && !user_empty);
    assign credit_ok   = (credits_q != '0);

    assign out_valid   = head_avail && credit_ok;
    assign out_data    = out_valid ? head[DATA_W:1] : '0;
    assign out_last    = out_valid && head_last;
    assign out_ctrl    = sel_ctrl;
    assign out_fire    = out_valid && out_ready;
    assign ctrl_pop    = out_fire && sel_ctrl;
    assign user_pop    = out_fire && sel_user;

    assign credits_avail  = credits_q;
    assign credit_ovf_err = ovf_q;

    always_comb begin
        state_d       = state_q;
        in_sof_d      = in_sof_q;
        pkt_ctrl_d    = pkt_ctrl_q;
        ready_en_d    = 1'b1;
        credits_d     = credits_q;
        ovf_d         = ovf_q;
        ctrl_wr_ptr_d = ctrl_push ? ctrl_wr_ptr_q + PTR_W'(1) : ctrl_wr_ptr_q;
        user_wr_ptr_d = user_push ? user_wr_ptr_q + PTR_W'(1) : user_wr_ptr_q;
        ctrl_rd_ptr_d = ctrl_pop  ? ctrl_rd_ptr_q + PTR_W'(1) : ctrl_rd_ptr_q;
        user_rd_ptr_d = user_pop  ? user_rd_ptr_q + PTR_W'(1) : user_rd_ptr_q;
        ctrl_cnt_d    = ctrl_cnt_q + CNT_W'(ctrl_push) - CNT_W'(ctrl_pop);
        user_cnt_d    = user_cnt_q + CNT_W'(user_push) - CNT_W'(user_pop);

        if (in_fire) begin
            in_sof_d = in_last;
            if (in_sof_q) begin
                pkt_ctrl_d = in_ctrl;
            end
        end

        // A state only releases on the last word, so packets never interleave.
        case (state_q)
            IDLE: begin
                if (!ctrl_empty) begin
                    state_d = SEND_CTRL;
                end else if (!user_empty) begin
                    state_d = SEND_USER;
                end
            end
            SEND_CTRL, SEND_USER: begin
                if (out_fire && head_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (out_fire && !credit_return) begin
            credits_d = credits_q - CREDIT_W'(1);
        end else if (credit_return && !out_fire) begin
            if (credits_q == CREDIT_W'(MAX_CREDITS)) begin
                ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + CREDIT_W'(1);
            end
        end
    end

`ifdef NET_TX_ARB_STATS_EN
    always_comb begin
        stat_ctrl_d  = stat_ctrl_q  + 32'(ctrl_pop && head_last);
        stat_user_d  = stat_user_q  + 32'(user_pop && head_last);
        stat_stall_d = stat_stall_q + 32'(head_avail && !credit_ok);
    end

    assign stat_ctrl_pkts    = stat_ctrl_q;
    assign stat_user_pkts    = stat_user_q;
    assign stat_credit_stall = stat_stall_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_sof_q      <= 1'b1;
            pkt_ctrl_q    <= 1'b0;
            ready_en_q    <= 1'b0;
            credits_q     <= CREDIT_W'(INIT_CREDITS);
            ovf_q         <= 1'b0;
            ctrl_wr_ptr_q <= '0;
            ctrl_rd_ptr_q <= '0;
            user_wr_ptr_q <= '0;
            user_rd_ptr_q <= '0;
            ctrl_cnt_q    <= '0;
            user_cnt_q    <= '0;
`ifdef NET_TX_ARB_STATS_EN
            stat_ctrl_q   <= '0;
            stat_user_q   <= '0;
            stat_stall_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            in_sof_q      <= in_sof_d;
            pkt_ctrl_q    <= pkt_ctrl_d;
            ready_en_q    <= ready_en_d;
            credits_q     <= credits_d;
            ovf_q         <= ovf_d;
            ctrl_wr_ptr_q <= ctrl_wr_ptr_d;
            ctrl_rd_ptr_q <= ctrl_rd_ptr_d;
            user_wr_ptr_q <= user_wr_ptr_d;
            user_rd_ptr_q <= user_rd_ptr_d;
            ctrl_cnt_q    <= ctrl_cnt_d;
            user_cnt_q    <= user_cnt_d;
`ifdef NET_TX_ARB_STATS_EN
            stat_ctrl_q   <= stat_ctrl_d;
            stat_user_q   <= stat_user_d;
            stat_stall_q  <= stat_stall_d;
`endif
        end
    end

    // Storage needs no reset: the counts decide what is valid.
    always_ff @(posedge clk) begin
        if (ctrl_push) begin
            ctrl_mem[ctrl_wr_ptr_q] <= {in_data, in_last};
        end
        if (user_push) begin
            user_mem[user_wr_ptr_q] <= {in_data, in_last};
        end
    end

endmodule

// File: tb/tb_net_tx_credit_arbiter.sv
// Scoreboard bench for net_tx_credit_arbiter: per-class expected word queues, a credit
// arithmetic model and packet-order tracking, driven by directed and random traffic.
module tb_net_tx_credit_arbiter;

    localparam int DW   = 128;
    localparam int INIT = 16;
    localparam int MAXC = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ctrl = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ctrl;
    logic          out_ready = 1'b0;
    logic          credit_return = 1'b0;
    logic [5:0]    credits_avail;
    logic          credit_ovf_err;
`ifdef NET_TX_ARB_STATS_EN
    logic [31:0]   stat_ctrl_pkts, stat_user_pkts, stat_credit_stall;
`endif

    net_tx_credit_arbiter #(
        .DATA_W(DW), .FIFO_DEPTH(16), .INIT_CREDITS(INIT), .MAX_CREDITS(MAXC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ctrl(in_ctrl),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ctrl(out_ctrl),
        .out_ready(out_ready),
        .credit_return(credit_return), .credits_avail(credits_avail),
        .credit_ovf_err(credit_ovf_err)
`ifdef NET_TX_ARB_STATS_EN
        ,
        .stat_ctrl_pkts(stat_ctrl_pkts), .stat_user_pkts(stat_user_pkts),
        .stat_credit_stall(stat_credit_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int seq = 0;
    int accept_cyc = 0;
    int first_valid_cyc = 0;
    bit seen_valid = 0;
    bit rand_mode = 0;

    logic [DW:0] exp_ctrl[$];
    logic [DW:0] exp_user[$];
    logic [DW:0] mon_word;
    bit          pkt_order[$];
    bit          mon_in_pkt = 0;
    bit          mon_cls = 0;
    int          model_cred = INIT;
    bit          model_ovf = 0;
    int          model_ctrl_pkts = 0;
    int          model_user_pkts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [DW:0] act, input logic [DW:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the expected word for the presented class and runs the credit model.
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("credits_avail", 129'(credits_avail), 129'(model_cred));
            check_output("credit_ovf_err", 129'(credit_ovf_err), 129'(model_ovf));
            if (model_cred == 0) check_output("no_valid_without_credit", 129'(out_valid), 129'(0));
            if (out_valid && !seen_valid) begin
                seen_valid = 1;
                first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if ((out_ctrl && exp_ctrl.size() == 0) || (!out_ctrl && exp_user.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_word: got ctrl=%0b data %0h required no word", out_ctrl, out_data);
                end else begin
                    mon_word = out_ctrl ? exp_ctrl.pop_front() : exp_user.pop_front();
                    check_output("out_data", 129'(out_data), 129'(mon_word[DW:1]));
                    check_output("out_last", 129'(out_last), 129'(mon_word[0]));
                    if (mon_word[0]) begin
                        if (out_ctrl) model_ctrl_pkts++;
                        else model_user_pkts++;
                    end
                end
                if (!mon_in_pkt) pkt_order.push_back(out_ctrl);
                else check_output("no_interleave", 129'(out_ctrl), 129'(mon_cls));
                mon_in_pkt = !out_last;
                mon_cls = out_ctrl;
            end
            if (out_valid && out_ready && !credit_return) model_cred--;
            else if (credit_return && !(out_valid && out_ready)) begin
                if (model_cred == MAXC) model_ovf = 1;
                else model_cred++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                out_ready = ($urandom_range(0, 3) != 0);
                credit_return = ($urandom_range(0, 1) == 1);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_ctrl.delete();
        exp_user.delete();
        pkt_order.delete();
        mon_in_pkt = 0;
        seen_valid = 0;
        model_cred = INIT;
        model_ovf = 0;
        model_ctrl_pkts = 0;
        model_user_pkts = 0;
        #1;
        check_output("rst_in_ready", 129'(in_ready), 129'(0));
        check_output("rst_out_valid", 129'(out_valid), 129'(0));
        check_output("rst_out_last", 129'(out_last), 129'(0));
        check_output("rst_out_ctrl", 129'(out_ctrl), 129'(0));
        check_output("rst_out_data", 129'(out_data), 129'(0));
        check_output("rst_credits", 129'(credits_avail), 129'(INIT));
        check_output("rst_ovf", 129'(credit_ovf_err), 129'(0));
`ifdef NET_TX_ARB_STATS_EN
        check_output("rst_stat_ctrl", 129'(stat_ctrl_pkts), 129'(0));
        check_output("rst_stat_user", 129'(stat_user_pkts), 129'(0));
        check_output("rst_stat_stall", 129'(stat_credit_stall), 129'(0));
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("in_ready_before_first_clk", 129'(in_ready), 129'(0));
        @(posedge clk);
        #1;
        check_output("in_ready_after_first_clk", 129'(in_ready), 129'(1));
    endtask

    // Called and returns at posedge+1; pushes each word to its class queue on acceptance.
    task automatic send_pkt(input bit cls, input int len, input bit term);
        logic [DW-1:0] w;
        bit accepted;
        int budget;
        for (int i = 0; i < len; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            w[15:0] = seq[15:0];
            seq++;
            in_data = w;
            in_last = term && (i == len - 1);
            in_ctrl = (i == 0) ? cls : 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            accepted = 0;
            budget = 0;
            while (!accepted) begin
                @(negedge clk);
                if (in_ready) begin
                    accepted = 1;
                    if (i == 0) accept_cyc = cyc;
                    if (cls) exp_ctrl.push_back({w, in_last});
                    else exp_user.push_back({w, in_last});
                end
                @(posedge clk);
                #1;
                if (!accepted) begin
                    budget++;
                    if (budget > 2000) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL in_accept_timeout: got in_ready=0 for %0d cycles required acceptance", budget);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_credit(input int n);
        for (int i = 0; i < n; i++) begin
            credit_return = 1'b1;
            @(posedge clk);
            #1;
            credit_return = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_ctrl.size() != 0 || exp_user.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("drain_pending_words", 129'(exp_ctrl.size() + exp_user.size()), 129'(0));
    endtask

    task automatic check_order_010(input string name);
        logic [7:0] bits = '0;
        foreach (pkt_order[i]) bits = {bits[6:0], pkt_order[i]};
        check_output({name, "_count"}, 129'(pkt_order.size()), 129'(3));
        check_output(name, 129'(bits), 129'(8'b010));
    endtask

    initial begin
        logic [DW-1:0] w;
        int n;
        #2;
        do_reset();

        // One 3-word user packet with a ready link.
        out_ready = 1'b1;
        send_pkt(0, 3, 1);
        wait_drain(100);
        check_output("first_word_latency", 129'(first_valid_cyc - accept_cyc), 129'(2));
        check_output("credits_after_3", 129'(credits_avail), 129'(13));

        // Controller packet arriving behind an in-flight user packet waits for its end.
        out_ready = 1'b0;
        pulse_credit(3);
        pkt_order.delete();
        send_pkt(0, 4, 1);
        send_pkt(1, 2, 1);
        send_pkt(0, 2, 1);
        out_ready = 1'b1;
        wait_drain(200);
        check_order_010("prio_order_mid");
        check_output("credits_after_prio", 129'(credits_avail), 129'(8));

        // Credit exhaustion mid-packet, then refill.
        pulse_credit(8);
        send_pkt(0, 10, 1);
        send_pkt(0, 10, 1);
        repeat (10) @(posedge clk);
        #1;
        check_output("stall_out_valid", 129'(out_valid), 129'(0));
        check_output("stall_credits", 129'(credits_avail), 129'(0));
        check_output("stall_backlog", 129'(exp_user.size()), 129'(4));
`ifdef NET_TX_ARB_STATS_EN
        check_output("stall_counter_nonzero", 129'(stat_credit_stall != 0), 129'(1));
`endif
        pulse_credit(4);
        wait_drain(200);
        check_output("credits_after_refill", 129'(credits_avail), 129'(0));

        // Full user queue: user target blocked, controller target open, push+pop on full.
        out_ready = 1'b0;
        pulse_credit(16);
        pkt_order.delete();
        send_pkt(0, 16, 1);
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_data = w;
        in_valid = 1'b1;
        in_last = 1'b1;
        in_ctrl = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("full_in_ready", 129'(in_ready), 129'(0));
            @(posedge clk);
            #1;
        end
        in_ctrl = 1'b1;
        @(negedge clk);
        check_output("ctrl_ready_while_user_full", 129'(in_ready), 129'(1));
        exp_ctrl.push_back({w, 1'b1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fork
            send_pkt(0, 1, 1);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check_output("full_push_pop_ready", 129'(in_ready), 129'(0));
            end
        join
        pulse_credit(2);
        wait_drain(300);
        check_order_010("prio_order_full");
        check_output("credits_after_full", 129'(credits_avail), 129'(0));

        // Saturation, sticky overflow, and send+return in the same cycle.
        pulse_credit(32);
        check_output("credits_at_max", 129'(credits_avail), 129'(32));
        check_output("ovf_before", 129'(credit_ovf_err), 129'(0));
        pulse_credit(1);
        check_output("credits_saturated", 129'(credits_avail), 129'(32));
        check_output("ovf_set", 129'(credit_ovf_err), 129'(1));
        send_pkt(0, 12, 1);
        wait_drain(200);
        check_output("credits_at_20", 129'(credits_avail), 129'(20));
        out_ready = 1'b0;
        send_pkt(0, 1, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("simul_word_presented", 129'(out_valid), 129'(1));
        out_ready = 1'b1;
        credit_return = 1'b1;
        @(posedge clk);
        #1;
        credit_return = 1'b0;
        check_output("credits_send_and_return", 129'(credits_avail), 129'(20));
        check_output("simul_word_sent", 129'(exp_user.size()), 129'(0));
        check_output("ovf_sticky", 129'(credit_ovf_err), 129'(1));

        // Random packets, random back-pressure and returns; in_ctrl randomised past the first word.
        rand_mode = 1;
        for (int p = 0; p < 150; p++) begin
            send_pkt(1'($urandom_range(0, 1)), $urandom_range(1, 6), 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain(4000);
        rand_mode = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        credit_return = 1'b0;
`ifdef NET_TX_ARB_STATS_EN
        check_output("stat_ctrl_random", 129'(stat_ctrl_pkts), 129'(model_ctrl_pkts));
        check_output("stat_user_random", 129'(stat_user_pkts), 129'(model_user_pkts));
`endif

        // Reset in the middle of a packet, then clean traffic afterwards.
        out_ready = 1'b0;
        send_pkt(0, 3, 0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b1;
        for (int p = 0; p < 2; p++) send_pkt(1, 2, 1);
        for (int p = 0; p < 3; p++) send_pkt(0, 2, 1);
        wait_drain(200);
        check_output("credits_after_reset_traffic", 129'(credits_avail), 129'(6));
`ifdef NET_TX_ARB_STATS_EN
        check_output("stat_ctrl_pkts", 129'(stat_ctrl_pkts), 129'(2));
        check_output("stat_user_pkts", 129'(stat_user_pkts), 129'(3));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion required finish before 1000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
